// File: rtl/arm_pipeline_pkg.sv
// Shared pipeline types and constants for the PipelinedARMv8 stages.
// The IF/ID record defined here is produced by fetch and consumed by decode.
package arm_pipeline_pkg;

  localparam int          PC_WIDTH  = 64;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [31:0]         instruction;
    logic                valid;
  } if_id_t;

  // Empty IF/ID slot: used at reset and whenever a redirect discards the wrong-path fetch.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc          = {PC_WIDTH{1'b0}};
    b.pc_plus4    = {PC_WIDTH{1'b0}};
    b.instruction = NOP_INSTR;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction ROM with a combinational read port.
// Contents are loaded externally through the memory array.
module instruction_memory #(
  parameter int DEPTH = 64
) (
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [31:0]              word
);

  logic [31:0] memory [DEPTH];

  assign word = memory[addr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM lookup and the IF/ID pipeline register.
// A branch redirect flushes IF/ID and wins over stall; stall freezes PC, IF/ID and the counter.
module fetch_stage
  import arm_pipeline_pkg::*;
#(
  parameter int                  IMEM_DEPTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [PC_WIDTH-1:0] if_id_pc_plus4,
  output logic [31:0]         if_id_instruction,
  output logic                if_id_valid,
  output logic [31:0]         fetch_count
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  if_id_t              if_id_q, if_id_d;
  logic [31:0]         count_q, count_d;
  logic [IDX_W-1:0]    rom_index_s;
  logic [31:0]         rom_word_s;
  logic [PC_WIDTH-1:0] pc_plus4_s;

  // PC bits above the ROM index are ignored, so fetches wrap modulo IMEM_DEPTH*4.
  assign rom_index_s = pc_q[IDX_W+1:2];
  assign pc_plus4_s  = pc_q + {{(PC_WIDTH-3){1'b0}}, 3'd4};

  instruction_memory #(.DEPTH(IMEM_DEPTH)) instruction_memory (
    .addr (rom_index_s),
    .word (rom_word_s)
  );

  // Next-state selection: redirect, then stall, then sequential fetch.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    count_d = count_q;
    if (branch_taken) begin
      pc_d    = branch_target & ~{{(PC_WIDTH-2){1'b0}}, 2'b11};
      if_id_d = if_id_bubble();
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
    end else begin
      if_id_d.pc          = pc_q;
      if_id_d.pc_plus4    = pc_plus4_s;
      if_id_d.instruction = rom_word_s;
      if_id_d.valid       = 1'b1;
      pc_d                = pc_plus4_s;
      count_d             = count_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      if_id_q <= if_id_bubble();
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      count_q <= count_d;
    end
  end

  assign pc                = pc_q;
  assign if_id_pc          = if_id_q.pc;
  assign if_id_pc_plus4    = if_id_q.pc_plus4;
  assign if_id_instruction = if_id_q.instruction;
  assign if_id_valid       = if_id_q.valid;
  assign fetch_count       = count_q;

endmodule
